// File: rtl/dsp_mac_pkg.sv
// Shared types and the round/saturate helper used by the MAC slice variants.
package dsp_mac_pkg;

  typedef enum logic [1:0] {
    PA_A    = 2'b00,
    PA_DPA  = 2'b01,
    PA_DMA  = 2'b10,
    PA_NEGA = 2'b11
  } preadd_mode_e;

  // Wide enough for any accumulator this family instantiates, plus the rounding carry.
  localparam int SAT_WMAX = 128;

  typedef struct packed {
    logic                       sat;
    logic signed [SAT_WMAX-1:0] value;
  } sat_res_t;

  // Round-half-up arithmetic shift followed by clamp to a signed ow-bit range.
  function automatic sat_res_t sat_round(input logic signed [SAT_WMAX-1:0] acc,
                                         input int shift,
                                         input int ow);
    logic signed [SAT_WMAX-1:0] one;
    logic signed [SAT_WMAX-1:0] r;
    logic signed [SAT_WMAX-1:0] max_v;
    logic signed [SAT_WMAX-1:0] min_v;
    sat_res_t                   res;
    one = SAT_WMAX'(1);
    r   = acc;
    if (shift > 0) begin
      r = r + (one <<< (shift - 1));
    end
    r     = r >>> shift;
    max_v = (one <<< (ow - 1)) - one;
    min_v = -(one <<< (ow - 1));
    res.sat   = 1'b0;
    res.value = r;
    if (r > max_v) begin
      res.sat   = 1'b1;
      res.value = max_v;
    end else if (r < min_v) begin
      res.sat   = 1'b1;
      res.value = min_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/dsp_preadd.sv
// Input register stage plus mode-selected exact pre-adder (D +/- A, A, -A),
// two clock-enabled stages; reused by the complex-multiplier block.
module dsp_preadd
  import dsp_mac_pkg::*;
#(
  parameter int AW = 27,
  parameter int BW = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  preadd_mode_e         mode,
  input  logic                 acc_en,
  input  logic signed [AW-1:0] ain,
  input  logic signed [AW-1:0] din,
  input  logic signed [BW-1:0] bin,
  output logic                 s2_valid,
  output logic                 s2_acc_en,
  output logic signed [AW:0]   s2_pre,
  output logic signed [BW-1:0] s2_b
);

  localparam int PW = AW + 1;

  logic                 s1_valid_q,  s1_valid_d;
  logic                 s1_acc_en_q, s1_acc_en_d;
  preadd_mode_e         s1_mode_q,   s1_mode_d;
  logic signed [AW-1:0] s1_a_q,      s1_a_d;
  logic signed [AW-1:0] s1_d_q,      s1_d_d;
  logic signed [BW-1:0] s1_b_q,      s1_b_d;
  logic                 s2_valid_q,  s2_valid_d;
  logic                 s2_acc_en_q, s2_acc_en_d;
  logic signed [PW-1:0] s2_pre_q,    s2_pre_d;
  logic signed [BW-1:0] s2_b_q,      s2_b_d;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] d_ext;
  logic signed [PW-1:0] pre_sum;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    a_ext   = {s1_a_q[AW-1], s1_a_q};
    d_ext   = {s1_d_q[AW-1], s1_d_q};
    pre_sum = a_ext;
    case (s1_mode_q)
      PA_A:    pre_sum = a_ext;
      PA_DPA:  pre_sum = d_ext + a_ext;
      PA_DMA:  pre_sum = d_ext - a_ext;
      PA_NEGA: pre_sum = -a_ext;
    endcase

    s1_valid_d  = s1_valid_q;
    s1_acc_en_d = s1_acc_en_q;
    s1_mode_d   = s1_mode_q;
    s1_a_d      = s1_a_q;
    s1_d_d      = s1_d_q;
    s1_b_d      = s1_b_q;
    s2_valid_d  = s2_valid_q;
    s2_acc_en_d = s2_acc_en_q;
    s2_pre_d    = s2_pre_q;
    s2_b_d      = s2_b_q;
    if (ce) begin
      s1_valid_d  = in_valid;
      s1_acc_en_d = acc_en;
      s1_mode_d   = mode;
      s1_a_d      = ain;
      s1_d_d      = din;
      s1_b_d      = bin;
      s2_valid_d  = s1_valid_q;
      s2_acc_en_d = s1_acc_en_q;
      s2_pre_d    = pre_sum;
      s2_b_d      = s1_b_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_acc_en_q <= 1'b0;
      s1_mode_q   <= PA_A;
      s1_a_q      <= '0;
      s1_d_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_acc_en_q <= 1'b0;
      s2_pre_q    <= '0;
      s2_b_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_acc_en_q <= s1_acc_en_d;
      s1_mode_q   <= s1_mode_d;
      s1_a_q      <= s1_a_d;
      s1_d_q      <= s1_d_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_acc_en_q <= s2_acc_en_d;
      s2_pre_q    <= s2_pre_d;
      s2_b_q      <= s2_b_d;
    end
  end

  assign s2_valid  = s2_valid_q;
  assign s2_acc_en = s2_acc_en_q;
  assign s2_pre    = s2_pre_q;
  assign s2_b      = s2_b_q;

endmodule

// File: rtl/dsp_preadd_mac.sv
// Pre-adder MAC slice: P = ACC +/- ((D +/- A) * B), then round-half-up shift
// and saturation; five clock-enabled stages sized for one DSP primitive.
module dsp_preadd_mac
  import dsp_mac_pkg::*;
#(
  parameter int AW    = 27,
  parameter int BW    = 18,
  parameter int GW    = 8,
  parameter int SHIFT = 0,
  parameter int OW    = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [1:0]           mode,
  input  logic                 acc_en,
  input  logic signed [AW-1:0] ain,
  input  logic signed [AW-1:0] din,
  input  logic signed [BW-1:0] bin,
  output logic                 out_valid,
  output logic signed [OW-1:0] pout,
  output logic                 sat
);

  localparam int PW  = AW + 1;
  localparam int MW  = PW + BW;
  localparam int ACW = MW + GW;

  logic                 s2_valid;
  logic                 s2_acc_en;
  logic signed [PW-1:0] s2_pre;
  logic signed [BW-1:0] s2_b;

  dsp_preadd #(
    .AW(AW),
    .BW(BW)
  ) u_preadd (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .in_valid (in_valid),
    .mode     (preadd_mode_e'(mode)),
    .acc_en   (acc_en),
    .ain      (ain),
    .din      (din),
    .bin      (bin),
    .s2_valid (s2_valid),
    .s2_acc_en(s2_acc_en),
    .s2_pre   (s2_pre),
    .s2_b     (s2_b)
  );

  logic                  s3_valid_q,  s3_valid_d;
  logic                  s3_acc_en_q, s3_acc_en_d;
  logic signed [MW-1:0]  prod_q,      prod_d;
  logic                  s4_valid_q,  s4_valid_d;
  logic signed [ACW-1:0] acc_q,       acc_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [OW-1:0]  pout_q,      pout_d;
  logic                  sat_q,       sat_d;

  logic signed [SAT_WMAX-1:0] acc_ext;
  sat_res_t                   rnd;

  always_comb begin
    acc_ext = SAT_WMAX'(acc_q);
    rnd     = sat_round(acc_ext, SHIFT, OW);

    s3_valid_d  = s3_valid_q;
    s3_acc_en_d = s3_acc_en_q;
    prod_d      = prod_q;
    s4_valid_d  = s4_valid_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    pout_d      = pout_q;
    sat_d       = sat_q;
    if (ce) begin
      s3_valid_d  = s2_valid;
      s3_acc_en_d = s2_acc_en;
      prod_d      = MW'(s2_pre) * MW'(s2_b);
      s4_valid_d  = s3_valid_q;
      // Bubbles leave the running sum alone so accumulation chains survive gaps.
      if (s3_valid_q) begin
        acc_d = s3_acc_en_q ? acc_q + ACW'(prod_q) : ACW'(prod_q);
      end
      out_valid_d = s4_valid_q;
      if (s4_valid_q) begin
        pout_d = OW'(rnd.value);
        sat_d  = rnd.sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q  <= 1'b0;
      s3_acc_en_q <= 1'b0;
      prod_q      <= '0;
      s4_valid_q  <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      pout_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      s3_valid_q  <= s3_valid_d;
      s3_acc_en_q <= s3_acc_en_d;
      prod_q      <= prod_d;
      s4_valid_q  <= s4_valid_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      pout_q      <= pout_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pout      = pout_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_dsp_preadd_mac.sv
// Directed bench for dsp_preadd_mac: default build plus a SHIFT=4 build on shared inputs.
module tb_dsp_preadd_mac;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ce;
  logic               in_valid;
  logic [1:0]         mode;
  logic               acc_en;
  logic signed [26:0] ain;
  logic signed [26:0] din;
  logic signed [17:0] bin;

  logic               out_valid, sat;
  logic signed [47:0] pout;
  logic               out_valid4, sat4;
  logic signed [47:0] pout4;

  int errors = 0;
  int checks = 0;

  localparam longint MAXV = (longint'(1) <<< 47) - 1;
  localparam longint P4   = longint'((1 << 26) - 1) * longint'((1 << 17) - 1);
  localparam longint K16  = (longint'(1) <<< 47) - (longint'(1) <<< 30) - (longint'(1) <<< 21) + 16;

  always #5 clk = ~clk;

  dsp_preadd_mac u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .in_valid (in_valid),
    .mode     (mode),
    .acc_en   (acc_en),
    .ain      (ain),
    .din      (din),
    .bin      (bin),
    .out_valid(out_valid),
    .pout     (pout),
    .sat      (sat)
  );

  dsp_preadd_mac #(.SHIFT(4)) u_dut_s4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .in_valid (in_valid),
    .mode     (mode),
    .acc_en   (acc_en),
    .ain      (ain),
    .din      (din),
    .bin      (bin),
    .out_valid(out_valid4),
    .pout     (pout4),
    .sat      (sat4)
  );

  task automatic drive(input int v, input int m, input int ae, input int a, input int d, input int b);
    in_valid = 1'(v);
    mode     = 2'(m);
    acc_en   = 1'(ae);
    ain      = 27'(a);
    din      = 27'(d);
    bin      = 18'(b);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input int ae, input int m, input int a, input int d, input int b);
    drive(1, m, ae, a, d, b);
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic check_out(input string tag,
                           input logic ov, input logic signed [47:0] op, input logic os,
                           input logic ev, input longint ep, input logic es);
    logic signed [47:0] ep48;
    ep48 = 48'(ep);
    checks++;
    assert (ov === ev) else begin
      errors++;
      $error("FAIL %s out_valid: observed=%0b expected=%0b", tag, ov, ev);
    end
    checks++;
    assert (op === ep48) else begin
      errors++;
      $error("FAIL %s pout: observed=%0d expected=%0d", tag, op, ep48);
    end
    checks++;
    assert (os === es) else begin
      errors++;
      $error("FAIL %s sat: observed=%0b expected=%0b", tag, os, es);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check_out("reset", out_valid, pout, sat, 1'b0, 0, 1'b0);
    check_out("reset_s4", out_valid4, pout4, sat4, 1'b0, 0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1: single sample, A*B with A=3, B=-5
    send(0, 0, 3, 0, -5);
    check_out("t1_lat1", out_valid, pout, sat, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check_out("t1_lat", out_valid, pout, sat, 1'b0, 0, 1'b0);
    end
    idle();
    check_out("t1_out", out_valid, pout, sat, 1'b1, -15, 1'b0);
    idle();
    check_out("t1_pulse", out_valid, pout, sat, 1'b0, -15, 1'b0);

    // 2: pre-adder modes back to back, then the negated-minimum corner
    send(0, 1, 4, 10, 7);
    send(0, 2, 4, 10, 7);
    send(0, 3, 4, 10, 7);
    send(0, 3, -(1 << 26), 0, -(1 << 17));
    idle();
    check_out("t2_dpa", out_valid, pout, sat, 1'b1, 98, 1'b0);
    idle();
    check_out("t2_dma", out_valid, pout, sat, 1'b1, 42, 1'b0);
    idle();
    check_out("t2_nega", out_valid, pout, sat, 1'b1, -28, 1'b0);
    idle();
    check_out("t2_negmin", out_valid, pout, sat, 1'b1, -(longint'(1) <<< 43), 1'b0);
    idle();
    check_out("t2_drain", out_valid, pout, sat, 1'b0, -(longint'(1) <<< 43), 1'b0);

    // 3: accumulation chain with a bubble between samples 2 and 3
    send(0, 0, 1, 0, 2);
    send(1, 0, 2, 0, 2);
    idle();
    send(1, 0, 3, 0, 2);
    send(1, 0, 4, 0, 2);
    check_out("t3_s1", out_valid, pout, sat, 1'b1, 2, 1'b0);
    idle();
    check_out("t3_s2", out_valid, pout, sat, 1'b1, 6, 1'b0);
    idle();
    check_out("t3_bubble", out_valid, pout, sat, 1'b0, 6, 1'b0);
    idle();
    check_out("t3_s3", out_valid, pout, sat, 1'b1, 12, 1'b0);
    idle();
    check_out("t3_s4", out_valid, pout, sat, 1'b1, 20, 1'b0);

    // 4: long positive accumulation into saturation
    for (int i = 1; i <= 20; i++) begin
      send((i > 1) ? 1 : 0, 0, (1 << 26) - 1, 0, (1 << 17) - 1);
      if (i >= 5) begin
        check_out("t4_acc", out_valid, pout, sat, 1'b1, longint'(i - 4) * P4, 1'b0);
        if (i == 20) begin
          check_out("t4_16th", out_valid, pout, sat, 1'b1, K16, 1'b0);
        end
      end
    end
    for (int n = 17; n <= 20; n++) begin
      idle();
      check_out("t4_sat", out_valid, pout, sat, 1'b1, MAXV, 1'b1);
    end
    idle();
    check_out("t4_hold", out_valid, pout, sat, 1'b0, MAXV, 1'b1);

    // 5: SHIFT=4 rounding on the second build
    send(0, 0, 3, 0, 8);
    send(0, 0, -3, 0, 8);
    send(0, 0, 1, 0, 8);
    send(0, 0, -3, 0, 3);
    idle();
    check_out("t5_p24", out_valid4, pout4, sat4, 1'b1, 2, 1'b0);
    idle();
    check_out("t5_m24", out_valid4, pout4, sat4, 1'b1, -1, 1'b0);
    idle();
    check_out("t5_p8", out_valid4, pout4, sat4, 1'b1, 1, 1'b0);
    idle();
    check_out("t5_m9", out_valid4, pout4, sat4, 1'b1, -1, 1'b0);
    idle();
    check_out("t5_drain", out_valid4, pout4, sat4, 1'b0, -1, 1'b0);

    // 6a: clock-enable stall with the pipeline full
    for (int i = 1; i <= 5; i++) begin
      send((i > 1) ? 1 : 0, 0, i, 0, 1);
    end
    check_out("t6_pre", out_valid, pout, sat, 1'b1, 1, 1'b0);
    ce = 1'b0;
    drive(1, 0, 1, 100, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("t6_stall", out_valid, pout, sat, 1'b1, 1, 1'b0);
    end
    ce = 1'b1;
    idle();
    check_out("t6_o2", out_valid, pout, sat, 1'b1, 3, 1'b0);
    idle();
    check_out("t6_o3", out_valid, pout, sat, 1'b1, 6, 1'b0);
    idle();
    check_out("t6_o4", out_valid, pout, sat, 1'b1, 10, 1'b0);
    idle();
    check_out("t6_o5", out_valid, pout, sat, 1'b1, 15, 1'b0);
    idle();
    check_out("t6_end", out_valid, pout, sat, 1'b0, 15, 1'b0);

    // 6b: asynchronous reset with three samples in flight
    send(1, 0, 7, 0, 1);
    send(1, 0, 8, 0, 1);
    send(1, 0, 9, 0, 1);
    send(1, 0, 10, 0, 1);
    idle();
    check_out("t6_prerst", out_valid, pout, sat, 1'b1, 22, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_out("t6_async", out_valid, pout, sat, 1'b0, 0, 1'b0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      check_out("t6_nostale", out_valid, pout, sat, 1'b0, 0, 1'b0);
    end
    send(1, 0, 5, 0, 1);
    for (int i = 0; i < 3; i++) begin
      idle();
      check_out("t6_wait", out_valid, pout, sat, 1'b0, 0, 1'b0);
    end
    idle();
    check_out("t6_fresh", out_valid, pout, sat, 1'b1, 5, 1'b0);
    idle();
    check_out("t6_done", out_valid, pout, sat, 1'b0, 5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
